// File: rtl/mux_nto1_pipe.sv
// N-to-1 data selector feeding a registered valid/ready output stage.
// Build option MUX_NTO1_SKID_EN adds a skid entry so that o_ready is driven from a register.
module mux_nto1_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 4,
  localparam int unsigned SEL_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_err,
  output logic                             o_valid,
  input  logic                             i_ready,
  input  logic                             i_err_clr,
  output logic                             o_err_sticky
);

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_err;
  logic                  accept;
  logic                  deliver;
  logic                  sticky_q, sticky_d;

  // Fully decoded select: any code with no matching channel yields zero data and an error.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (i_sel == SEL_WIDTH'(k)) begin
        sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  // Set has priority over a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (accept && sel_err) begin
      sticky_d = 1'b1;
    end else if (i_err_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign o_err_sticky = sticky_q;

`ifdef MUX_NTO1_SKID_EN

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_err_q, main_err_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_err_q, skid_err_d;

  assign accept  = i_valid && ready_q;
  assign deliver = (state_q != StEmpty) && i_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (accept && !deliver) begin
          skid_data_d = sel_data;
          skid_err_d  = sel_err;
          state_d     = StTwo;
        end else if (deliver && !accept) begin
          state_d = StEmpty;
        end else if (accept && deliver) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end
      end
      StTwo: begin
        if (deliver) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Ready for next cycle is decided now so the output comes straight from a flop.
    ready_d = (state_d != StTwo);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StEmpty;
      ready_q     <= 1'b1;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = (state_q != StEmpty);
  assign o_data  = main_data_q;
  assign o_err   = main_err_q;

`else

  typedef enum logic {StEmpty, StOne} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_err_q, main_err_d;

  assign o_valid = (state_q == StOne);
  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign deliver = o_valid && i_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    if (accept) begin
      main_data_d = sel_data;
      main_err_d  = sel_err;
      state_d     = StOne;
    end else if (deliver) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
    end
  end

  assign o_data = main_data_q;
  assign o_err  = main_err_q;

`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: a 3-input/32-bit and a 16-input/8-bit instance,
// each compared every cycle against a queue-based model of the items the block holds.
module tb_mux_nto1_pipe;

`ifdef MUX_NTO1_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 3-input, 32-bit instance
  logic [95:0] d3 = '0;
  logic [1:0]  s3 = '0;
  logic        v3 = 1'b0, r3 = 1'b1, c3 = 1'b0;
  logic        rdy3, oe3, ov3, os3;
  logic [31:0] od3;

  // 16-input, 8-bit instance
  logic [127:0] d16 = '0;
  logic [3:0]   s16 = '0;
  logic         v16 = 1'b0, r16 = 1'b1, c16 = 1'b0;
  logic         rdy16, oe16, ov16, os16;
  logic [7:0]   od16;

  mux_nto1_pipe #(.DATA_WIDTH(32), .NUM_INPUTS(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d3), .i_sel(s3), .i_valid(v3), .o_ready(rdy3),
    .o_data(od3), .o_err(oe3), .o_valid(ov3), .i_ready(r3), .i_err_clr(c3), .o_err_sticky(os3)
  );

  mux_nto1_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d16), .i_sel(s16), .i_valid(v16), .o_ready(rdy16),
    .o_data(od16), .o_err(oe16), .o_valid(ov16), .i_ready(r16), .i_err_clr(c16),
    .o_err_sticky(os16)
  );

  int n_total = 0;
  int n_pass = 0;

  // Model: a queue of {err, data} items currently held by the block, head = presented item.
  logic [32:0] q3[$];
  logic        st3 = 1'b0;
  logic [8:0]  q16[$];
  logic        st16 = 1'b0;

  // Observed vector: {valid, ready, data (masked when invalid), err, sticky}
  logic [35:0] act3;
  logic [11:0] act16;
  assign act3  = {ov3, rdy3, ov3 ? od3 : 32'h0, ov3 & oe3, os3};
  assign act16 = {ov16, rdy16, ov16 ? od16 : 8'h0, ov16 & oe16, os16};

  function automatic logic exp_rdy(input int sz, input logic r);
    return SKID ? (sz < 2) : ((sz == 0) || r);
  endfunction

  function automatic logic [32:0] item3(input logic [95:0] d, input logic [1:0] s);
    logic [95:0] sh;
    if (s < 2'd3) begin
      sh = d >> (32 * s);
      return {1'b0, sh[31:0]};
    end
    return {1'b1, 32'h0};
  endfunction

  function automatic logic [8:0] item16(input logic [127:0] d, input logic [3:0] s);
    logic [127:0] sh;
    sh = d >> (8 * s);
    return {1'b0, sh[7:0]};
  endfunction

  function automatic logic [35:0] exp3();
    logic [32:0] h;
    h = '0;
    if (q3.size() != 0) h = q3[0];
    return {q3.size() != 0, exp_rdy(q3.size(), r3), h[31:0], h[32], st3};
  endfunction

  function automatic logic [11:0] exp16();
    logic [8:0] h;
    h = '0;
    if (q16.size() != 0) h = q16[0];
    return {q16.size() != 0, exp_rdy(q16.size(), r16), h[7:0], h[8], st16};
  endfunction

  task automatic commit3();
    logic acc, del;
    acc = v3 && exp_rdy(q3.size(), r3);
    del = (q3.size() != 0) && r3;
    if (del) void'(q3.pop_front());
    if (acc) q3.push_back(item3(d3, s3));
    if (acc && s3 == 2'd3) st3 = 1'b1;
    else if (c3) st3 = 1'b0;
  endtask

  task automatic commit16();
    logic acc, del;
    acc = v16 && exp_rdy(q16.size(), r16);
    del = (q16.size() != 0) && r16;
    if (del) void'(q16.pop_front());
    if (acc) q16.push_back(item16(d16, s16));
    if (c16) st16 = 1'b0;
  endtask

  // Drive the 3-input instance just after an edge, then settle to mid-cycle.
  task automatic drive3(input logic v, input logic [1:0] s, input logic r, input logic c);
    @(posedge clk);
    #1;
    v3 = v; s3 = s; r3 = r; c3 = c;
    #3;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({ov3, od3, oe3, os3, ov16, od16, oe16, os16} !== '0) begin
      $display("FAIL reset_outputs got=%h want=0", {ov3, od3, oe3, os3, ov16, od16, oe16, os16});
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    drive3(1'b0, 2'd0, 1'b1, 1'b0);
    n_total++;
    if (act3 !== exp3() || rdy3 !== 1'b1) $display("FAIL reset_release got=%h want=%h", act3, exp3());
    else n_pass++;
    commit3();
  endtask

  task automatic test_select();
    d3 = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 6; i++) begin
      drive3(i < 3, 2'(i), 1'b1, 1'b0);
      n_total++;
      if (act3 !== exp3()) $display("FAIL select cyc%0d got=%h want=%h", i, act3, exp3());
      else n_pass++;
      commit3();
    end
  endtask

  task automatic test_error();
    // Rows of {valid, sel[1:0], ready, clr}
    logic [4:0] tab[8];
    tab = '{5'b1_11_1_0, 5'b0_00_1_0, 5'b0_00_1_1, 5'b0_00_1_0,
            5'b1_11_1_1, 5'b0_00_1_0, 5'b1_00_1_1, 5'b0_00_1_0};
    for (int i = 0; i < 8; i++) begin
      drive3(tab[i][4], tab[i][3:2], tab[i][1], tab[i][0]);
      n_total++;
      if (act3 !== exp3()) $display("FAIL error cyc%0d got=%h want=%h", i, act3, exp3());
      else n_pass++;
      commit3();
    end
  endtask

  task automatic test_backpressure();
    int sent, got;
    sent = 0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      d3 = {$urandom(), $urandom(), $urandom()};
      s3 = 2'($urandom_range(0, 2));
      v3 = (sent < 8);
      r3 = ((i % 4) == 0) || ((i % 4) == 3);
      c3 = 1'b0;
      #3;
      n_total++;
      if (act3 !== exp3()) $display("FAIL backpressure cyc%0d got=%h want=%h", i, act3, exp3());
      else n_pass++;
      if (ov3 && r3) got++;
      if (v3 && rdy3) sent++;
      commit3();
    end
    n_total++;
    if (got !== 8) $display("FAIL backpressure_count got=%0d want=8", got);
    else n_pass++;
  endtask

  task automatic test_fill();
    int accepted;
    accepted = 0;
    // Leave an error item behind so the sticky flag is set going into the fill.
    drive3(1'b1, 2'd3, 1'b1, 1'b0);
    commit3();
    drive3(1'b0, 2'd0, 1'b1, 1'b0);
    n_total++;
    if (act3 !== exp3()) $display("FAIL fill_pre got=%h want=%h", act3, exp3());
    else n_pass++;
    commit3();
    d3 = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 6; i++) begin
      drive3(1'b1, 2'd1, 1'b0, 1'b0);
      n_total++;
      if (act3 !== exp3()) $display("FAIL fill cyc%0d got=%h want=%h", i, act3, exp3());
      else n_pass++;
      if (rdy3) accepted++;
      commit3();
    end
    n_total++;
    if (accepted !== (SKID ? 2 : 1)) begin
      $display("FAIL fill_capacity got=%0d want=%0d", accepted, SKID ? 2 : 1);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    #2;
    v3 = 1'b0; r3 = 1'b1; c3 = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({ov3, od3, oe3, os3, rdy3} !== {35'h0, 1'b1}) begin
      $display("FAIL reset_mid got=%h want=%h", {ov3, od3, oe3, os3, rdy3}, {35'h0, 1'b1});
    end else n_pass++;
    q3.delete();
    st3 = 1'b0;
    #10;
    rst_n = 1'b1;
    drive3(1'b0, 2'd0, 1'b0, 1'b0);
    n_total++;
    if (act3 !== exp3() || rdy3 !== 1'b1) $display("FAIL reset_mid_release got=%h want=%h", act3, exp3());
    else n_pass++;
    commit3();
  endtask

  task automatic test_wide_random();
    int nxt;
    nxt = 0;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk);
      #1;
      d16 = {$urandom(), $urandom(), $urandom(), $urandom()};
      s16 = (i < 64) ? 4'(nxt) : 4'($urandom_range(0, 15));
      v16 = (i < 64) ? 1'b1 : (i < 100) && ($urandom_range(0, 3) != 0);
      r16 = (i < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      c16 = ($urandom_range(0, 7) == 0);
      #3;
      n_total++;
      if (act16 !== exp16()) $display("FAIL wide cyc%0d got=%h want=%h", i, act16, exp16());
      else n_pass++;
      if (v16 && rdy16) nxt++;
      commit16();
    end
    n_total++;
    if (nxt < 16) $display("FAIL wide_coverage got=%0d want>=16", nxt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_select();
    test_error();
    test_backpressure();
    test_fill();
    test_reset_mid();
    test_wide_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised N-to-1 data selector with a registered, valid/ready-handshaked output stage, generalising the datapath's fixed 3-input selectors (ALU operand, forwarding, writeback source). Select is decoded in full: out-of-range selects yield zero data plus an error flag, never a latch. Sits between pipeline stages where the selected result must be registered and may be back-pressured by the consumer.

## Interface
- `DATA_WIDTH`, 32, width of each data channel
- `NUM_INPUTS`, 4, number of channels, 2..16
- `SEL_WIDTH`, `$clog2(NUM_INPUTS)`, select width (derived, not overridden)

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_data`  in  `NUM_INPUTS*DATA_WIDTH`  packed channels; channel k at bits `[k*DATA_WIDTH +: DATA_WIDTH]`
- `i_sel`  in  `SEL_WIDTH`  channel select, sampled with `i_valid`
- `i_valid`  in  1  upstream offers `i_data`/`i_sel`
- `o_ready`  out  1  block accepts this cycle
- `o_data`  out  `DATA_WIDTH`  selected data, registered
- `o_err`  out  1  `o_data` came from an out-of-range select
- `o_valid`  out  1  `o_data`/`o_err` valid
- `i_ready`  in  1  downstream accepts
- `i_err_clr`  in  1  clears `o_err_sticky`
- `o_err_sticky`  out  1  set on any accepted out-of-range select

## Operation
- Accept: `i_valid && o_ready`. Delivery: `o_valid && i_ready`.
- Selection: `i_sel < NUM_INPUTS` gives channel `i_sel`, err=0; otherwise data = 0, err=1.
- Storage: main register (drives outputs) plus optional skid register, each holding {data, err}.
- States (skid build): EMPTY, ONE (main full), TWO (main + skid full).
  - EMPTY: accept → ONE (main loaded).
  - ONE: accept and not delivery → TWO (skid loaded); delivery and not accept → EMPTY; both → ONE (main reloaded with new item).
  - TWO: delivery → ONE (main ← skid); no accept possible.
- `o_ready` = state != TWO, driven from a register only.
- Order preserved; no item dropped or duplicated.
- `o_data`/`o_err` hold stable while `o_valid && !i_ready`.
- Sticky error: set on accept with out-of-range select; `i_err_clr` clears; set wins over simultaneous clear.

## Timing
- Reset (async assert, sync release): `o_valid`=0, `o_data`=0, `o_err`=0, `o_err_sticky`=0, state EMPTY, `o_ready`=1 in first cycle after release.
- Latency: accept in cycle N → `o_valid`=1 in cycle N+1.
- Throughput: one item per cycle with `i_ready` held high.
- After `i_ready` deasserts: one additional accept (into skid), then `o_ready`=0 the next cycle.
- `i_data`/`i_sel` ignored when not accepted; no combinational path from any input to any output.
- Reset asserted mid-transfer: all buffered items discarded, outputs go to reset values immediately.
- `NUM_INPUTS` a power of two: no out-of-range select exists; `o_err` constant 0.

## Configuration
- `MUX_NTO1_SKID_EN` defined: two-entry skid implementation above; `o_ready` registered.
- Undefined: single main register only; states EMPTY/ONE; `o_ready = !o_valid || i_ready` (combinational from `i_ready`); accept and delivery in same cycle reload main. Latency, selection, error and reset behaviour identical.

## Test plan
- NUM_INPUTS=3, DATA_WIDTH=32, channels 0x11111111/0x22222222/0x33333333, sel 0,1,2 back-to-back, `i_ready`=1 → `o_data` same sequence on cycles N+1..N+3, `o_err`=0.
- Same config, sel=3 accepted → `o_data`=0, `o_err`=1, `o_err_sticky`=1 next cycle; `i_err_clr` pulse → sticky 0; clear concurrent with new sel=3 accept → sticky stays 1.
- Stream of 8 items with `i_ready` toggling 1,0,0,1 repeating → consumer sees all 8 in order, no duplicates, `o_data` stable while stalled; skid build: `o_ready`=0 only in TWO.
- `i_ready`=0 permanently, `i_valid`=1 → skid build accepts exactly 2 items then `o_ready`=0; non-skid build accepts 1.
- Reset asserted while in TWO → `o_valid`=0, `o_data`=0, `o_err_sticky`=0 without clock edge; `o_ready`=1 after release.
- NUM_INPUTS=16, DATA_WIDTH=8, all sel values 0..15 with random `i_ready` → scoreboard matches, `o_err` never 1.
